lfsr_checker: RTL

- Receive side of the 8-bit LFSR pattern source. The block takes the parallel LFSR state word, self-synchronises to the sequence, then checks every later word against its own prediction.
- Next-state polynomial: next = {cur[6:0], cur[1]^cur[2]^cur[3]^cur[7]}.
- Placed at the far end of a loopback or link. Its lock flag and error count drive the seven-segment display logic.

---
 rtl/lfsr_pkg.sv | 30 +++
 rtl/lfsr_checker_bcd_err_counter.sv | 54 +++++
 rtl/lfsr_checker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module : lfsr_pkg
// Brief  : Shared definitions for the 8-bit LFSR pattern source and checker:
//          word width, feedback tap mask, checker state type and the
//          next-state function.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

  localparam int LFSR_W = 8;

  // Feedback taps at bits 7,3,2,1
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'h8E;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Shift left, feeding the XOR of the tapped bits into bit 0
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & TAP_MASK)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_checker_bcd_err_counter.sv
// ============================================================================
// Module : bcd_err_counter
// Brief  : Three-digit BCD event counter with synchronous clear, saturating
//          at 999. Drives the seven-segment error display directly.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_err_counter (
  input  logic        clock,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic [11:0] o_bcd
);

  logic [11:0] r_bcd;
  logic [11:0] w_bcd_next;
  logic        w_sat;

  assign w_sat = (r_bcd == 12'h999);

  // Decimal increment with carry ripple between the three digits
  always_comb begin
    w_bcd_next = r_bcd;
    if (r_bcd[3:0] != 4'd9) begin
      w_bcd_next[3:0] = r_bcd[3:0] + 4'd1;
    end else begin
      w_bcd_next[3:0] = 4'd0;
      if (r_bcd[7:4] != 4'd9) begin
        w_bcd_next[7:4] = r_bcd[7:4] + 4'd1;
      end else begin
        w_bcd_next[7:4]  = 4'd0;
        w_bcd_next[11:8] = r_bcd[11:8] + 4'd1;
      end
    end
  end

  // Count register: reset and clear dominate, hold once 999 is reached
  always_ff @(posedge clock) begin
    if (!rst) begin
      r_bcd <= 12'h000;
    end else if (i_clr) begin
      r_bcd <= 12'h000;
    end else if (i_inc && !w_sat) begin
      r_bcd <= w_bcd_next;
    end
  end

  assign o_bcd = r_bcd;

endmodule

`default_nettype wire

// File: rtl/lfsr_checker.sv
// ============================================================================
// Module : lfsr_checker
// Brief  : Receive-side checker for the 8-bit LFSR pattern. Seeds from the
//          first non-zero word, verifies LOCK_CNT consecutive predictions
//          before declaring lock, then free-runs its prediction and counts
//          mismatches. LOSS_CNT consecutive misses drop lock.
//          Optional build macro LFSR_CHK_BCD_EN adds err_bcd, a 3-digit BCD
//          copy of the error count saturating at 999.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [LFSR_W-1:0] din,
  input  logic              clr_err,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              zero_err
`ifdef LFSR_CHK_BCD_EN
  ,
  output logic [11:0]       err_bcd
`endif
);

  localparam logic [3:0] c_LOCK_CNT = 4'(LOCK_CNT);
  localparam logic [3:0] c_LOSS_CNT = 4'(LOSS_CNT);

  state_t            r_state;
  logic [LFSR_W-1:0] r_pred;
  logic [3:0]        r_match_cnt;
  logic [3:0]        r_miss_cnt;
  logic              r_locked;
  logic              r_err_pulse;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_zero_err;

  logic              w_match;
  logic              w_zero;
  logic              w_err;
  logic [LFSR_W-1:0] w_next_din;
  logic [LFSR_W-1:0] w_next_pred;
  logic [3:0]        w_match_inc;
  logic [3:0]        w_miss_inc;
  logic              w_cnt_sat;

  assign w_match     = (din == r_pred);
  assign w_zero      = (din == '0);
  assign w_next_din  = lfsr_next(din);
  assign w_next_pred = lfsr_next(r_pred);
  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_miss_inc  = r_miss_cnt + 4'd1;
  assign w_err       = din_valid && (r_state == LOCKED) && !w_match;
  assign w_cnt_sat   = (r_err_cnt == {CNT_W{1'b1}});

  // Synchronisation FSM and prediction register; all state holds when stalled
  always_ff @(posedge clock) begin
    if (!rst) begin
      r_state     <= SEARCH;
      r_pred      <= '0;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 4'd0;
      r_locked    <= 1'b0;
    end else if (din_valid) begin
      case (r_state)
        SEARCH: begin
          // An all-zero word is the LFSR lockup state and can never seed
          if (!w_zero) begin
            r_pred      <= w_next_din;
            r_match_cnt <= 4'd0;
            r_state     <= VERIFY;
          end
        end
        VERIFY: begin
          if (w_match) begin
            r_pred      <= w_next_din;
            r_match_cnt <= w_match_inc;
            if (w_match_inc == c_LOCK_CNT) begin
              r_state    <= LOCKED;
              r_locked   <= 1'b1;
              r_miss_cnt <= 4'd0;
            end
          end else if (w_zero) begin
            r_match_cnt <= 4'd0;
            r_state     <= SEARCH;
          end else begin
            r_pred      <= w_next_din;
            r_match_cnt <= 4'd0;
          end
        end
        LOCKED: begin
          if (w_match) begin
            r_pred     <= w_next_din;
            r_miss_cnt <= 4'd0;
          end else begin
            // Free-run on our own prediction so one bad word costs one error
            r_pred <= w_next_pred;
            if (w_miss_inc == c_LOSS_CNT) begin
              r_miss_cnt <= 4'd0;
              r_locked   <= 1'b0;
              r_state    <= SEARCH;
            end else begin
              r_miss_cnt <= w_miss_inc;
            end
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Error strobe and saturating counter; clear beats a same-cycle increment
  always_ff @(posedge clock) begin
    if (!rst) begin
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (clr_err) begin
        r_err_cnt <= '0;
      end else if (w_err && !w_cnt_sat) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky flag for any received all-zero word
  always_ff @(posedge clock) begin
    if (!rst) begin
      r_zero_err <= 1'b0;
    end else if (clr_err) begin
      r_zero_err <= 1'b0;
    end else if (din_valid && w_zero) begin
      r_zero_err <= 1'b1;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign zero_err  = r_zero_err;

`ifdef LFSR_CHK_BCD_EN
  bcd_err_counter u_bcd_err_counter (
    .clock (clock),
    .rst   (rst),
    .i_inc (w_err),
    .i_clr (clr_err),
    .o_bcd (err_bcd)
  );
`endif

endmodule

`default_nettype wire
